prbs7_checker: RTL and testbench

//  Serial PRBS7 checker; downstream consumer of the lfsr block (x^7+x^6+1, next = {q[5:0], q[6]^q[5]}).

---
 rtl/prbs7_checker.sv | 142 ++++++++++++++
 tb/tb_prbs7_checker.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/prbs7_checker.sv
// Serial PRBS7 (x^7+x^6+1) checker: self-synchronises to the incoming stream,
// locks, then counts bit errors against a free-running local reference.
module prbs7_checker #(
  parameter int unsigned SYNC_CHECK  = 16,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             data_in,
  output logic             locked,
  output logic             error_pulse,
  output logic             lock_lost,
  output logic             zero_detect,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned CHK_W  = $clog2(SYNC_CHECK + 1);
  localparam int unsigned CONS_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    CHECK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [6:0]        sreg_q, sreg_d;
  logic [2:0]        fill_q, fill_d;
  logic [CHK_W-1:0]  chk_q, chk_d;
  logic [CONS_W-1:0] consec_q, consec_d;
  logic [CNT_W-1:0]  err_d, bit_d;
  logic              locked_d, error_pulse_d, lock_lost_d, zero_d;
  logic              pbit, mismatch;

  assign pbit     = sreg_q[6] ^ sreg_q[5];
  assign mismatch = data_in ^ pbit;

  always_comb begin
    state_d       = state_q;
    sreg_d        = sreg_q;
    fill_d        = fill_q;
    chk_d         = chk_q;
    consec_d      = consec_q;
    err_d         = err_count;
    bit_d         = bit_count;
    error_pulse_d = 1'b0;
    lock_lost_d   = 1'b0;

    if (enable) begin
      case (state_q)
        IDLE: begin
          sreg_d  = {sreg_q[5:0], data_in};
          fill_d  = 3'd1;
          state_d = FILL;
        end
        FILL: begin
          sreg_d = {sreg_q[5:0], data_in};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd6) begin
            chk_d   = '0;
            state_d = CHECK;
          end
        end
        CHECK: begin
          sreg_d = {sreg_q[5:0], data_in};
          if (sreg_q == '0 || mismatch) begin
            chk_d = '0;
          end else if (chk_q == CHK_W'(SYNC_CHECK - 1)) begin
            chk_d    = '0;
            consec_d = '0;
            state_d  = LOCKED;
          end else begin
            chk_d = chk_q + CHK_W'(1);
          end
        end
        LOCKED: begin
          // Reference free-runs on its own prediction so a single flipped
          // input bit cannot corrupt the following predictions.
          sreg_d = {sreg_q[5:0], pbit};
          if (bit_count != '1) bit_d = bit_count + CNT_W'(1);
          if (mismatch) begin
            error_pulse_d = 1'b1;
            if (err_count != '1) err_d = err_count + CNT_W'(1);
            if (consec_q == CONS_W'(LOSS_THRESH - 1)) begin
              lock_lost_d = 1'b1;
              consec_d    = '0;
              fill_d      = '0;
              state_d     = FILL;
            end else begin
              consec_d = consec_q + CONS_W'(1);
            end
          end else begin
            consec_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (clear) begin
      err_d = '0;
      bit_d = '0;
    end

    locked_d = (state_d == LOCKED);
    zero_d   = (state_d == CHECK) && (sreg_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      fill_q      <= '0;
      chk_q       <= '0;
      consec_q    <= '0;
      err_count   <= '0;
      bit_count   <= '0;
      locked      <= 1'b0;
      error_pulse <= 1'b0;
      lock_lost   <= 1'b0;
      zero_detect <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      fill_q      <= fill_d;
      chk_q       <= chk_d;
      consec_q    <= consec_d;
      err_count   <= err_d;
      bit_count   <= bit_d;
      locked      <= locked_d;
      error_pulse <= error_pulse_d;
      lock_lost   <= lock_lost_d;
      zero_detect <= zero_d;
    end
  end

endmodule

// File: tb/tb_prbs7_checker.sv
// Directed bench for prbs7_checker: default instance plus a CNT_W=4 instance
// sharing the same stimulus, used for counter saturation.
module tb_prbs7_checker;

  logic clk = 1'b0;
  logic reset_n, clear, enable, data_in;
  logic locked, error_pulse, lock_lost, zero_detect;
  logic [15:0] err_count, bit_count;
  logic s_locked, s_error_pulse, s_lock_lost, s_zero_detect;
  logic [3:0] s_err_count, s_bit_count;
  logic [6:0] q;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prbs7_checker dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .data_in(data_in),
    .locked(locked), .error_pulse(error_pulse), .lock_lost(lock_lost),
    .zero_detect(zero_detect), .err_count(err_count), .bit_count(bit_count)
  );

  prbs7_checker #(.SYNC_CHECK(16), .LOSS_THRESH(4), .CNT_W(4)) dut_small (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable), .data_in(data_in),
    .locked(s_locked), .error_pulse(s_error_pulse), .lock_lost(s_lock_lost),
    .zero_detect(s_zero_detect), .err_count(s_err_count), .bit_count(s_bit_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic b, input logic en, input logic clr);
    data_in = b;
    enable  = en;
    clear   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      q = {q[5:0], q[6] ^ q[5]};
      step(q[0], 1'b1, 1'b0);
    end
  endtask

  task automatic flip(input logic clr);
    q = {q[5:0], q[6] ^ q[5]};
    step(~q[0], 1'b1, clr);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; enable = 1'b0; data_in = 1'b0;
    q = 7'b1100111;
    #12;
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    chk("rst_bit", bit_count, 0);
    chk("rst_zero", zero_detect, 0);
    reset_n = 1'b1;

    // Clean stream: lock on the 23rd bit
    clean(22);
    chk("lock_not_yet", locked, 0);
    clean(1);
    chk("lock_at_23", locked, 1);
    chk("lock_bit0", bit_count, 0);
    clean(254);
    chk("clean_err", err_count, 0);
    chk("clean_bit", bit_count, 254);
    chk("small_bit_sat", s_bit_count, 15);
    chk("clean_pulse", error_pulse, 0);

    // Single flipped bit
    flip(1'b0);
    chk("flip_pulse", error_pulse, 1);
    chk("flip_err", err_count, 1);
    chk("flip_locked", locked, 1);
    chk("flip_no_loss", lock_lost, 0);
    clean(1);
    chk("flip_pulse_off", error_pulse, 0);
    chk("flip_err_hold", err_count, 1);
    chk("flip_bit", bit_count, 256);

    // Clear beats the same-cycle bit_count increment
    clean(0);
    q = {q[5:0], q[6] ^ q[5]};
    step(q[0], 1'b1, 1'b1);
    chk("clear_err", err_count, 0);
    chk("clear_bit", bit_count, 0);

    // Burst of LOSS_THRESH errors drops lock, then relock
    for (int i = 0; i < 3; i++) begin
      flip(1'b0);
      chk("burst_locked", locked, 1);
      chk("burst_no_loss", lock_lost, 0);
    end
    flip(1'b0);
    chk("burst_loss", lock_lost, 1);
    chk("burst_unlocked", locked, 0);
    chk("burst_err", err_count, 4);
    chk("burst_bit", bit_count, 4);
    clean(1);
    chk("loss_pulse_off", lock_lost, 0);
    clean(21);
    chk("relock_not_yet", locked, 0);
    clean(1);
    chk("relock", locked, 1);
    chk("relock_err", err_count, 4);
    chk("relock_bit", bit_count, 4);
    chk("relock_small_err", s_err_count, 4);

    // 20 isolated errors: small counter saturates at 15
    for (int i = 1; i <= 20; i++) begin
      flip(1'b0);
      clean(1);
      if (i == 11) begin
        chk("sat_small_reach", s_err_count, 15);
        chk("sat_big_reach", err_count, 15);
      end
    end
    chk("sat_small", s_err_count, 15);
    chk("sat_big", err_count, 24);
    chk("sat_locked", locked, 1);
    chk("sat_bit", bit_count, 44);
    flip(1'b1);
    chk("clear_vs_err_big", err_count, 0);
    chk("clear_vs_err_small", s_err_count, 0);
    chk("clear_vs_err_pulse", error_pulse, 1);

    // enable low: state holds, no pulses
    step(1'b1, 1'b0, 1'b0);
    chk("en0_pulse", error_pulse, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("en0_pulse2", error_pulse, 0);
    chk("en0_locked", locked, 1);
    chk("en0_bit", bit_count, 0);
    clean(3);
    chk("en1_bit", bit_count, 3);
    chk("en1_err", err_count, 0);
    chk("en1_pulse", error_pulse, 0);

    // Asynchronous reset between edges while locked
    flip(1'b0);
    clean(1);
    chk("pre_rst_err", err_count, 1);
    chk("pre_rst_bit", bit_count, 5);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_err", err_count, 0);
    chk("arst_bit", bit_count, 0);
    chk("arst_small_bit", s_bit_count, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // All-zero stream: zero_detect from CHECK entry, never locks
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (i == 6) chk("zero_fill", zero_detect, 0);
      if (i == 7) chk("zero_check_entry", zero_detect, 1);
      chk("zero_locked", locked, 0);
    end
    chk("zero_end", zero_detect, 1);
    chk("zero_err", err_count, 0);
    chk("zero_bit", bit_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
